// File: rtl/dpu_axi_read_arbiter.sv
// AXI4 read-port arbiter: NUM_REQ requesters share one master read port, one
// whole burst at a time, with ARID tagged by grant index and R routed back by grant.
`timescale 1ns/1ps

module dpu_axi_read_arbiter_rlane #(
  parameter int ID_W = 4,
  parameter int DA_W = 32
) (
  input  logic            sel,
  input  logic            m_rvalid,
  input  logic            m_rlast,
  input  logic [ID_W-1:0] m_rid,
  input  logic [DA_W-1:0] m_rdata,
  input  logic [1:0]      m_rresp,
  output logic            s_rvalid,
  output logic            s_rlast,
  output logic [ID_W-1:0] s_rid,
  output logic [DA_W-1:0] s_rdata,
  output logic [1:0]      s_rresp
);
  // Non-selected lanes see an idle, all-zero R channel.
  assign s_rvalid = sel & m_rvalid;
  assign s_rlast  = sel & m_rlast;
  assign s_rid    = sel ? m_rid   : '0;
  assign s_rdata  = sel ? m_rdata : '0;
  assign s_rresp  = sel ? m_rresp : '0;
endmodule

module dpu_axi_read_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int AXI_WIDTH_ID  = 4,
  parameter int AXI_WIDTH_AD  = 32,
  parameter int AXI_WIDTH_DA  = 32,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic [NUM_REQ*AXI_WIDTH_ID-1:0]   S_ARID,
  input  logic [NUM_REQ*AXI_WIDTH_AD-1:0]   S_ARADDR,
  input  logic [NUM_REQ*8-1:0]              S_ARLEN,
  input  logic [NUM_REQ*3-1:0]              S_ARSIZE,
  input  logic [NUM_REQ*2-1:0]              S_ARBURST,
  input  logic [NUM_REQ-1:0]                S_ARVALID,
  output logic [NUM_REQ-1:0]                S_ARREADY,
  output logic [NUM_REQ*AXI_WIDTH_ID-1:0]   S_RID,
  output logic [NUM_REQ*AXI_WIDTH_DA-1:0]   S_RDATA,
  output logic [NUM_REQ*2-1:0]              S_RRESP,
  output logic [NUM_REQ-1:0]                S_RLAST,
  output logic [NUM_REQ-1:0]                S_RVALID,
  input  logic [NUM_REQ-1:0]                S_RREADY,
  output logic [AXI_WIDTH_ID+1:0]           M_ARID,
  output logic [AXI_WIDTH_AD-1:0]           M_ARADDR,
  output logic [7:0]                        M_ARLEN,
  output logic [2:0]                        M_ARSIZE,
  output logic [1:0]                        M_ARBURST,
  output logic                              M_ARVALID,
  input  logic                              M_ARREADY,
  input  logic [AXI_WIDTH_ID+1:0]           M_RID,
  input  logic [AXI_WIDTH_DA-1:0]           M_RDATA,
  input  logic [1:0]                        M_RRESP,
  input  logic                              M_RLAST,
  input  logic                              M_RVALID,
  output logic                              M_RREADY,
  output logic                              BUSY
);
  localparam int GW = 2;
  localparam int IW = AXI_WIDTH_ID;
  localparam int AW = AXI_WIDTH_AD;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nxt;

  logic [GW-1:0]      grant, last_grant, pick;
  logic               found;
  logic [IW-1:0]      ar_id, pick_id;
  logic [AW-1:0]      ar_addr, pick_addr;
  logic [7:0]         ar_len, pick_len;
  logic [2:0]         ar_size, pick_size;
  logic [1:0]         ar_burst, pick_burst;
  logic [NUM_REQ-1:0] lane_sel;
  logic               r_done;
  logic [1:0]         unused_rid_tag;

  // Routing is by the grant register, so the tag bits on RID are not needed.
  assign unused_rid_tag = M_RID[IW+1:IW];

  // RR: first requester above last_grant, else wrap to the lowest index.
  // Fixed: the first pass is skipped and the second pass scans from 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && S_ARVALID[i] && PRIORITY_MODE == 0 && GW'(i) > last_grant) begin
        found = 1'b1;
        pick  = GW'(i);
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && S_ARVALID[i]) begin
        found = 1'b1;
        pick  = GW'(i);
      end
  end

  always_comb begin
    pick_id    = '0;
    pick_addr  = '0;
    pick_len   = '0;
    pick_size  = '0;
    pick_burst = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick == GW'(i)) begin
        pick_id    = S_ARID[i*IW +: IW];
        pick_addr  = S_ARADDR[i*AW +: AW];
        pick_len   = S_ARLEN[i*8 +: 8];
        pick_size  = S_ARSIZE[i*3 +: 3];
        pick_burst = S_ARBURST[i*2 +: 2];
      end
  end

  always_comb begin
    S_ARREADY = '0;
    for (int i = 0; i < NUM_REQ; i++)
      S_ARREADY[i] = ARESETn && state == IDLE && found && pick == GW'(i);
  end

  assign r_done = M_RVALID && M_RREADY && M_RLAST;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)     state_nxt = ADDR;
      ADDR:    if (M_ARREADY) state_nxt = DATA;
      DATA:    if (r_done)    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ-1);
      ar_id      <= '0;
      ar_addr    <= '0;
      ar_len     <= '0;
      ar_size    <= '0;
      ar_burst   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        grant    <= pick;
        ar_id    <= pick_id;
        ar_addr  <= pick_addr;
        ar_len   <= pick_len;
        ar_size  <= pick_size;
        ar_burst <= pick_burst;
      end
      if (state == DATA && r_done) last_grant <= grant;
    end
  end

  assign M_ARVALID = (state == ADDR);
  assign M_ARID    = {grant, ar_id};
  assign M_ARADDR  = ar_addr;
  assign M_ARLEN   = ar_len;
  assign M_ARSIZE  = ar_size;
  assign M_ARBURST = ar_burst;
  assign BUSY      = (state != IDLE);
  assign M_RREADY  = |(lane_sel & S_RREADY);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_sel[g] = (state == DATA) && (grant == GW'(g));
    dpu_axi_read_arbiter_rlane #(.ID_W(IW), .DA_W(AXI_WIDTH_DA)) u_lane (
      .sel      (lane_sel[g]),
      .m_rvalid (M_RVALID),
      .m_rlast  (M_RLAST),
      .m_rid    (M_RID[IW-1:0]),
      .m_rdata  (M_RDATA),
      .m_rresp  (M_RRESP),
      .s_rvalid (S_RVALID[g]),
      .s_rlast  (S_RLAST[g]),
      .s_rid    (S_RID[g*IW +: IW]),
      .s_rdata  (S_RDATA[g*AXI_WIDTH_DA +: AXI_WIDTH_DA]),
      .s_rresp  (S_RRESP[g*2 +: 2])
    );
  end
endmodule
